// File: rtl/bomb_sequence_checker.sv
// bomb_sequence_checker
// Consumer end of the BombSquad sequence path. Captures a seed from the game
// LFSR on start, regenerates the same sequence locally one state per player
// entry, and scores each entry as a hit (advance) or a miss (strike).
// Reaching STAGES hits defuses the bomb. Reaching MAX_STRIKES misses explodes it.

module bomb_sequence_checker #(
  parameter int unsigned STAGES      = 4,  // 1..15
  parameter int unsigned MAX_STRIKES = 3   // 1..3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] seed_in,
  input  logic       entry_valid,
  input  logic [7:0] entry,
  output logic       entry_ack,
  output logic       entry_hit,
  output logic [3:0] stage,
  output logic [1:0] strikes,
  output logic       armed,
  output logic       defused,
  output logic       exploded
);

  localparam logic [3:0] STAGES_L      = 4'(STAGES);
  localparam logic [1:0] MAX_STRIKES_L = 2'(MAX_STRIKES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_DEFUSED,
    S_EXPLODED
  } state_t;

  // One step of the many-to-one game LFSR. This must stay bit-identical to the generator.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], cur[1] ^ cur[2] ^ cur[3] ^ cur[7]};
  endfunction

  state_t     state_q,    state_d;
  logic [7:0] target_q,   target_d;
  logic [3:0] stage_q,    stage_d;
  logic [1:0] strikes_q,  strikes_d;
  logic       ack_q,      ack_d;
  logic       hit_q,      hit_d;
  logic       armed_q,    armed_d;
  logic       defused_q,  defused_d;
  logic       exploded_q, exploded_d;

  // Next-state logic: start wins over entries; entries count only while ARMED.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
    state_d   = state_q;
    target_d  = target_q;
    stage_d   = stage_q;
    strikes_d = strikes_q;
    ack_d     = 1'b0;
    hit_d     = 1'b0;

    if (start) begin
      // An all-zero seed would lock the LFSR, so fall back to the all-ones state.
      target_d  = (seed_in == 8'h00) ? 8'hFF : seed_in;
      stage_d   = 4'd0;
      strikes_d = 2'd0;
      state_d   = S_ARMED;
    end else if (entry_valid && (state_q == S_ARMED)) begin
      ack_d = 1'b1;
      if (entry == target_q) begin
        hit_d    = 1'b1;
        target_d = lfsr_next(target_q);
        stage_d  = stage_q + 4'd1;
        if (stage_d == STAGES_L) state_d = S_DEFUSED;
      end else begin
        strikes_d = strikes_q + 2'd1;
        if (strikes_d == MAX_STRIKES_L) state_d = S_EXPLODED;
      end
    end

    // The status flags are decoded from the next state, so the registered copies match the state register.
    armed_d    = (state_d == S_ARMED);
    defused_d  = (state_d == S_DEFUSED);
    exploded_d = (state_d == S_EXPLODED);
  end

  // State and output registers. A synchronous reset overrides everything else.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      state_q    <= S_IDLE;
      target_q   <= 8'hFF;
      stage_q    <= 4'd0;
      strikes_q  <= 2'd0;
      ack_q      <= 1'b0;
      hit_q      <= 1'b0;
      armed_q    <= 1'b0;
      defused_q  <= 1'b0;
      exploded_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      stage_q    <= stage_d;
      strikes_q  <= strikes_d;
      ack_q      <= ack_d;
      hit_q      <= hit_d;
      armed_q    <= armed_d;
      defused_q  <= defused_d;
      exploded_q <= exploded_d;
    end
  end

  assign entry_ack = ack_q;
  assign entry_hit = hit_q;
  assign stage     = stage_q;
  assign strikes   = strikes_q;
  assign armed     = armed_q;
  assign defused   = defused_q;
  assign exploded  = exploded_q;

endmodule

// File: tb/tb_bomb_sequence_checker.sv
// Testbench for bomb_sequence_checker.
// The stimulus runs one transaction per clock and pushes the expected outputs into a queue.
// The monitor compares the DUT against the front of the queue on each falling edge.
// The reference model tracks the seed and the number of hits so far. The expected
// code is the seed advanced by that many LFSR steps.

module tb_bomb_sequence_checker;

  localparam int STAGES      = 4;
  localparam int MAX_STRIKES = 3;

  logic       clk = 1'b0;
  logic       reset, start, entry_valid;
  logic [7:0] seed_in, entry;
  logic       entry_ack, entry_hit, armed, defused, exploded;
  logic [3:0] stage;
  logic [1:0] strikes;

  bomb_sequence_checker #(.STAGES(STAGES), .MAX_STRIKES(MAX_STRIKES)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .seed_in     (seed_in),
    .entry_valid (entry_valid),
    .entry       (entry),
    .entry_ack   (entry_ack),
    .entry_hit   (entry_hit),
    .stage       (stage),
    .strikes     (strikes),
    .armed       (armed),
    .defused     (defused),
    .exploded    (exploded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected output vector: {ack, hit, stage[3:0], strikes[1:0], armed, defused, exploded}
  logic [10:0] exp_q[$];
  int          cyc_q[$];
  int          cycle = 0;

  // Reference model state
  bit       m_armed, m_defused, m_exploded;
  bit [7:0] m_seed;
  int       m_hits, m_misses;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got ack=%b hit=%b stage=%0d strikes=%0d arm/def/exp=%b, want ack=%b hit=%b stage=%0d strikes=%0d arm/def/exp=%b",
               name, act[10], act[9], act[8:5], act[4:3], act[2:0],
               exp[10], exp[9], exp[8:5], exp[4:3], exp[2:0]);
    end
  endtask

  // Seed advanced k steps along the game sequence.
  function automatic bit [7:0] code_at(input bit [7:0] seed, input int k);
    bit [7:0] s = seed;
    for (int i = 0; i < k; i++) s = {s[6:0], s[1] ^ s[2] ^ s[3] ^ s[7]};
    return s;
  endfunction

  function automatic bit [7:0] model_expected();
    return code_at(m_seed, m_hits);
  endfunction

  // Drive one cycle of inputs, update the model, and queue the expected response.
  task automatic step(input bit rst, input bit st, input bit [7:0] sd,
                      input bit ev, input bit [7:0] ent);
    bit ack = 0, hit = 0;
    reset = rst; start = st; seed_in = sd; entry_valid = ev; entry = ent;
    if (rst) begin
      m_armed = 0; m_defused = 0; m_exploded = 0;
      m_seed = 8'hFF; m_hits = 0; m_misses = 0;
    end else if (st) begin
      m_seed = (sd == 8'h00) ? 8'hFF : sd;
      m_hits = 0; m_misses = 0;
      m_armed = 1; m_defused = 0; m_exploded = 0;
    end else if (ev && m_armed) begin
      ack = 1;
      if (ent == model_expected()) begin
        hit = 1;
        m_hits++;
        if (m_hits == STAGES) begin m_armed = 0; m_defused = 1; end
      end else begin
        m_misses++;
        if (m_misses == MAX_STRIKES) begin m_armed = 0; m_exploded = 1; end
      end
    end
    exp_q.push_back({ack, hit, 4'(m_hits), 2'(m_misses), m_armed, m_defused, m_exploded});
    cyc_q.push_back(cycle);
    cycle++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 0, 8'h00);
  endtask

  task automatic enter(input bit [7:0] code);
    step(0, 0, 8'h00, 1, code);
  endtask

  task automatic go(input bit [7:0] sd);
    step(0, 1, sd, 0, 8'h00);
  endtask

  // Monitor: compare the DUT outputs with the oldest pending expectation once the DUT has sampled it.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [10:0] e;
        int c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check($sformatf("cyc%0d", c),
              {entry_ack, entry_hit, stage, strikes, armed, defused, exploded}, e);
      end
    end
  end

  initial begin
    // Reset state
    step(1, 0, 8'h00, 0, 8'h00);
    step(1, 0, 8'h00, 0, 8'h00);
    idle();

    // Clean defuse with back-to-back entries
    go(8'hFF);
    enter(8'hFF); enter(8'hFE); enter(8'hFC); enter(8'hF9);
    idle();
    enter(8'h01);            // ignored while DEFUSED
    enter(8'hF3);

    // Three misses explode
    go(8'hFF);
    enter(8'h00); enter(8'h00); enter(8'h00);
    idle();
    enter(8'hFF);            // ignored while EXPLODED

    // Zero seed behaves as FF
    go(8'h00);
    enter(8'hFF);
    idle();

    // Hit, miss, hit: the expected code holds on a miss
    go(8'hFF);
    enter(8'hFF); enter(8'h00); enter(8'hFE);
    idle();

    // start and entry_valid together: start wins and the entry is dropped
    step(0, 1, 8'hFF, 1, 8'hFF);
    idle();

    // Entry while IDLE is ignored
    step(1, 0, 8'h00, 0, 8'h00);
    enter(8'hFF);

    // Reset mid-round at stage 2, then a clean restart
    go(8'hFF);
    enter(8'hFF); enter(8'hFE);
    step(1, 0, 8'h00, 0, 8'h00);
    idle();
    go(8'hFF);
    enter(8'hFF);

    // Reset overrides start and entry in the same cycle
    step(1, 1, 8'h55, 1, 8'h55);
    idle();

    // Randomized traffic, biased toward correct entries so rounds reach both outcomes
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 1) begin
        step(1, $urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1), 8'($urandom));
      end else if (r < 6) begin
        step(0, 1, ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
             $urandom_range(0, 1), 8'($urandom));
      end else if (r < 60) begin
        enter(($urandom_range(0, 3) != 0) ? model_expected() : 8'($urandom));
      end else begin
        idle();
      end
    end
    idle();

    // Let the monitor drain. An expired bound counts as a failure.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bomb_sequence_checker.md
# bomb_sequence_checker

Consumer end of the BombSquad sequence path. On `start` it captures one sample of the free-running 8-bit game LFSR as a seed. It then regenerates the same many-to-one LFSR sequence locally, one state per player entry, and compares each 8-bit player entry against the expected code. It counts correct stages and strikes, and reports a defused or exploded outcome to the game controller and display logic.

## Interface

Parameters:
- `STAGES`, default 4: number of correct entries required to defuse (1..15).
- `MAX_STRIKES`, default 3: wrong entries that cause an explosion (1..3).

Ports:
- `clk`  in  1: on-board 50 MHz clock.
- `reset`  in  1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `start`  in  1: one-cycle pulse; captures seed and begins or restarts a round.
- `seed_in`  in  8: current LFSR sample from the game sequence generator.
- `entry_valid`  in  1: one-cycle pulse, debounced upstream; `entry` is valid this cycle.
- `entry`  in  8: player's switch code.
- `entry_ack`  out  1: one-cycle pulse, the cycle after an accepted entry.
- `entry_hit`  out  1: valid with `entry_ack`; 1 means match, 0 means miss.
- `stage`  out  4: number of correct entries so far.
- `strikes`  out  2: number of wrong entries so far.
- `armed`  out  1: high in ARMED.
- `defused`  out  1: high in DEFUSED.
- `exploded`  out  1: high in EXPLODED.

## Operation

- LFSR step, identical to the generator: `next = {cur[6:0], cur[1]^cur[2]^cur[3]^cur[7]}`. It cycles through 255 states; 0x00 is a lock-up state.
- Seed capture: `target <= seed_in`. If `seed_in == 8'h00`, substitute `8'hFF` to avoid lock-up.
- State machine, with states IDLE, ARMED, DEFUSED, EXPLODED:
  - Reset: state = IDLE; `target` = 0xFF; `stage` = 0; `strikes` = 0; all 1-bit outputs = 0.
  - Any state, on `start`: capture seed, clear `stage` and `strikes`, go to ARMED. A restart is allowed mid-round and after an outcome.
  - ARMED, on `entry_valid` with `entry == target`:
    - `target <= next(target)`, `stage++`.
    - If the new `stage == STAGES`, go to DEFUSED.
  - ARMED, on `entry_valid` with `entry != target`:
    - `target` unchanged, `strikes++`.
    - If the new `strikes == MAX_STRIKES`, go to EXPLODED.
  - DEFUSED and EXPLODED are absorbing. In these states `entry_valid` is ignored and `entry_ack` does not fire; they exit only on `start` or `reset`.
  - IDLE ignores `entry_valid`.
- Counter widths: `stage` cannot exceed `STAGES` and `strikes` cannot exceed `MAX_STRIKES`; neither counter wraps.
- `target` is internal only and is never driven to a port.

## Timing

- All outputs are registered; no combinational input-to-output path.
- `entry_valid` in cycle N produces `entry_ack`, `entry_hit`, the updated `stage`/`strikes`, and the new state flags in cycle N+1.
- `start` in cycle N sets `armed` = 1 and clears counters in cycle N+1. `seed_in` is sampled in cycle N.
- `start` and `entry_valid` in the same cycle: `start` wins. The entry is dropped and produces no `entry_ack`.
- Back-to-back `entry_valid` on consecutive cycles: each is accepted; the second is compared against the already-stepped `target`.
- The final matching entry raises `defused`, clears `armed`, and produces `entry_ack`/`entry_hit=1` in the same N+1 cycle. A final miss does the same with `exploded` and `entry_hit=0`.
- `reset` overrides `start` and everything else in the same cycle.
- `entry_ack` is exactly one cycle wide. `entry_hit` is don't-care when `entry_ack` is 0; the checker drives it to 0 in that case.

## Test plan

- Reset, then `start` with `seed_in=FF`, then enter FE, FC, F9 wrongly ordered? No: enter FF, FE, FC, F9 (STAGES=4). Required: four acks with hit=1; `stage` goes 1..4; `defused`=1 on the cycle after the fourth entry; `strikes`=0.
- `start` with seed 0xFF, then enter 0x00 three times. Required: hit=0 each time; `strikes` goes 1, 2, 3; `exploded`=1 after the third; `stage`=0.
- `start` with `seed_in=00`. Required: behaves as seed FF; entry FF gives hit=1.
- `start` with seed FF, enter FF, then a miss (00), then FE. Required: hits 1/0/1; `stage`=2; `strikes`=1; the expected value does not advance on the miss.
- Same-cycle `start` and `entry_valid`; `entry_valid` while IDLE or DEFUSED. Required: no `entry_ack`; counters clear on `start` and are unchanged otherwise.
- `reset` asserted mid-round after stage=2. Required: next cycle state IDLE, all outputs 0; a following `start` with seed FF accepts FF first.
